// File: rtl/cnn_pkg.sv
// Shared constants for the CNN pooling pipeline stages.
// Holds the default sample width and a constant-foldable ceil(log2) helper.
package cnn_pkg;

    localparam int DWIDTH_DEF   = 20;
    localparam int MAX_COLS_DEF = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/max_pool_row_if.sv
// Sample stream into and out of the vertical pooling stage.
// The upstream side is the master; the pooling stage is the slave.
interface max_pool_row_if
    import cnn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);
    logic [DWIDTH-1:0] data_in;
    logic              valid_in;
    logic [DWIDTH-1:0] data_out;
    logic              valid_out;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/max_pool_row_line_buf_ram.sv
// One pooled row of samples: synchronous write, asynchronous read.
// Small enough to map onto distributed RAM.
module line_buf_ram
    import cnn_pkg::*;
#(
    parameter  int DWIDTH   = DWIDTH_DEF,
    parameter  int MAX_COLS = MAX_COLS_DEF,
    localparam int AW       = clog2(MAX_COLS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [MAX_COLS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_row.sv
// Vertical 2:1 max-pool: buffers an even row, then emits max(buffered, incoming)
// on the following odd row. With pooling off it is a registered pass-through.
module max_pool_row
    import cnn_pkg::*;
#(
    parameter  int DWIDTH   = DWIDTH_DEF,
    parameter  int MAX_COLS = MAX_COLS_DEF,
    localparam int COL_W    = clog2(MAX_COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_maxpool,
    input  logic             clear,
    input  logic [COL_W:0]   cfg_cols,
    max_pool_row_if.slave    bus
);

    logic [COL_W-1:0]  col;
    logic              row_odd;
    logic [COL_W:0]    cols_eff;
    logic [COL_W:0]    last_full;
    logic [COL_W-1:0]  last_col;
    logic              accept;
    logic              buf_we;
    logic [COL_W-1:0]  buf_waddr;
    logic [DWIDTH-1:0] buf_rdata;
    logic [DWIDTH-1:0] pooled;

    // Illegal row lengths are clamped into 1..MAX_COLS.
    always_comb begin
        cols_eff = cfg_cols;
        if (cfg_cols == '0) begin
            cols_eff = (COL_W+1)'(1);
        end else if (cfg_cols > (COL_W+1)'(MAX_COLS)) begin
            cols_eff = (COL_W+1)'(MAX_COLS);
        end
    end

    assign last_full = cols_eff - (COL_W+1)'(1);
    assign last_col  = last_full[COL_W-1:0];
    assign accept    = bus.valid_in && en_maxpool;

    // A sample arriving with clear always lands in column 0 of an even row.
    assign buf_we    = accept && (clear || !row_odd);
    assign buf_waddr = clear ? '0 : col;
    assign pooled    = (buf_rdata > bus.data_in) ? buf_rdata : bus.data_in;

    line_buf_ram #(
        .DWIDTH   (DWIDTH),
        .MAX_COLS (MAX_COLS)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (bus.data_in),
        .raddr (col),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            col           <= '0;
            row_odd       <= 1'b0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
        end else if (!en_maxpool) begin
            col           <= '0;
            row_odd       <= 1'b0;
            bus.data_out  <= bus.data_in;
            bus.valid_out <= bus.valid_in && !clear;
        end else if (clear) begin
            bus.valid_out <= 1'b0;
            if (accept && (last_col == '0)) begin
                col     <= '0;
                row_odd <= 1'b1;
            end else if (accept) begin
                col     <= COL_W'(1);
                row_odd <= 1'b0;
            end else begin
                col     <= '0;
                row_odd <= 1'b0;
            end
        end else if (accept) begin
            bus.valid_out <= row_odd;
            if (row_odd) begin
                bus.data_out <= pooled;
            end
            if (col == last_col) begin
                col     <= '0;
                row_odd <= !row_odd;
            end else begin
                col <= col + COL_W'(1);
            end
        end else begin
            bus.valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_pool_row.sv
// Directed bench for max_pool_row: a sample-count model of the 2x2 pool checked
// every cycle, plus literal output lists for each scenario.
module tb_max_pool_row;

    localparam int DW    = 20;
    localparam int MCOLS = 64;
    localparam int CW    = 6;

    logic          clk;
    logic          reset;
    logic          en_maxpool;
    logic          clear;
    logic [CW:0]   cfg_cols;

    max_pool_row_if #(.DWIDTH(DW)) bus ();

    max_pool_row #(
        .DWIDTH   (DW),
        .MAX_COLS (MCOLS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_maxpool (en_maxpool),
        .clear      (clear),
        .cfg_cols   (cfg_cols),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] got_q[$];

    // Model: position in the frame is a plain sample count since restart;
    // row parity and column are derived by division.
    logic [DW-1:0] row_mem [MCOLS];
    int            seen;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          chk_d;
    int            ncols;
    int            c;

    always @(posedge clk) begin
        ncols = (cfg_cols == 0) ? 1 : ((int'(cfg_cols) > MCOLS) ? MCOLS : int'(cfg_cols));
        chk_d = 1'b0;
        if (reset) begin
            seen  = 0;
            exp_v = 1'b0;
            exp_d = '0;
            chk_d = 1'b1;
        end else if (!en_maxpool) begin
            seen  = 0;
            exp_v = bus.valid_in && !clear;
            exp_d = bus.data_in;
            chk_d = exp_v;
        end else if (clear) begin
            exp_v = 1'b0;
            seen  = 0;
            if (bus.valid_in) begin
                row_mem[0] = bus.data_in;
                seen = 1;
            end
        end else if (bus.valid_in) begin
            c = seen % ncols;
            if (((seen / ncols) % 2) == 1) begin
                exp_v = 1'b1;
                exp_d = (row_mem[c] > bus.data_in) ? row_mem[c] : bus.data_in;
                chk_d = 1'b1;
            end else begin
                row_mem[c] = bus.data_in;
                exp_v = 1'b0;
            end
            seen = seen + 1;
        end else begin
            exp_v = 1'b0;
        end
        #1;
        n_cmp = n_cmp + 1;
        if (bus.valid_out !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL valid_out @%0t: got %b want %b", $time, bus.valid_out, exp_v);
        end
        if (chk_d) begin
            n_cmp = n_cmp + 1;
            if (bus.data_out !== exp_d) begin
                n_fail = n_fail + 1;
                $display("FAIL data_out @%0t: got %h want %h", $time, bus.data_out, exp_d);
            end
        end
        if (bus.valid_out === 1'b1) got_q.push_back(bus.data_out);
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic clr = 1'b0);
        @(negedge clk);
        bus.valid_in = v;
        bus.data_in  = d;
        clear        = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, DW'(0));
    endtask

    task automatic send_row(input logic [DW-1:0] vals[$], input int gap);
        foreach (vals[i]) begin
            cyc(1'b1, vals[i]);
            idle(gap);
        end
    endtask

    task automatic check_list(input string name, input logic [DW-1:0] want[$]);
        idle(2);
        n_cmp = n_cmp + 1;
        if (got_q.size() != want.size()) begin
            n_fail = n_fail + 1;
            $display("FAIL %s count: got %0d want %0d", name, got_q.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
            n_cmp = n_cmp + 1;
            if (got_q[i] !== want[i]) begin
                n_fail = n_fail + 1;
                $display("FAIL %s[%0d]: got %h want %h", name, i, got_q[i], want[i]);
            end
        end
        got_q.delete();
    endtask

    task automatic restart();
        cyc(1'b0, DW'(0), 1'b1);
        idle(1);
        got_q.delete();
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] ones[$];
        logic [DW-1:0] zeros[$];

        reset        = 1'b1;
        en_maxpool   = 1'b1;
        clear        = 1'b0;
        cfg_cols     = 7'd4;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;

        // Reset with random traffic, including a reset+clear overlap
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.valid_in = 1'($urandom);
            bus.data_in  = DW'($urandom);
            clear        = (i == 1);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = DW'(77);
        clear        = 1'b0;
        q = {};
        check_list("after_reset", q);
        restart();

        // Basic 2x2, back-to-back
        send_row('{5, 9, 2, 7}, 0);
        send_row('{3, 10, 2, 1}, 0);
        send_row('{0, 0, 0, 0}, 0);
        check_list("basic", '{5, 10, 2, 7});
        restart();

        // Same data with stalls
        send_row('{5, 9, 2, 7}, 2);
        send_row('{3, 10, 2, 1}, 2);
        check_list("stalls", '{5, 10, 2, 7});
        restart();

        // Pass-through, then re-enable buffers silently
        @(negedge clk);
        en_maxpool = 1'b0;
        cyc(1'b1, 20'hFFFFF);
        cyc(1'b0, 20'h00001);
        cyc(1'b1, 20'h00001);
        idle(1);
        check_list("passthru", '{20'hFFFFF, 20'h00001});
        @(negedge clk);
        en_maxpool = 1'b1;
        send_row('{11, 12, 13, 14}, 0);
        q = {};
        check_list("reenable", q);
        restart();

        // Clear mid-row with a sample on the clear cycle
        send_row('{8, 8}, 0);
        cyc(1'b1, DW'(1), 1'b1);
        send_row('{2, 3, 4}, 0);
        send_row('{6, 0, 5, 9}, 0);
        check_list("clear_mid", '{6, 2, 5, 9});
        restart();

        // cfg_cols = 0 behaves as 1
        @(negedge clk);
        cfg_cols = 7'd0;
        send_row('{3, 5, 9, 2}, 0);
        check_list("cols0", '{5, 9});
        restart();

        // cfg_cols = 1 with a sample on the clear cycle makes the next sample odd
        @(negedge clk);
        cfg_cols = 7'd1;
        cyc(1'b1, DW'(4), 1'b1);
        cyc(1'b1, DW'(7));
        check_list("cols1_clear", '{7});
        restart();

        // Full width, extreme values, two row pairs
        @(negedge clk);
        cfg_cols = 7'd64;
        for (int i = 0; i < MCOLS; i++) begin
            ones.push_back(20'hFFFFF);
            zeros.push_back(20'h00000);
        end
        send_row(ones, 0);
        send_row(zeros, 0);
        check_list("full_a", ones);
        send_row(zeros, 0);
        send_row(ones, 0);
        check_list("full_b", ones);

        // Oversized cfg_cols clamps to 64
        restart();
        @(negedge clk);
        cfg_cols = 7'd100;
        send_row(zeros, 0);
        send_row(ones, 0);
        check_list("cols_clamp", ones);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
